// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM for a small RISC-V subset sharing one memory port.
// Optional feature: define MC_CONTROL_TRAP_EN to trap unsupported instructions into HALT.
// Strobes are combinational from the registered state; the FSM waits on mem_ready, with an optional timeout.
module mc_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [3:0] alu_ctl,
  output logic       alu_bsel,
  output logic [2:0] state,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_nx;
  logic [7:0] wait_cnt;
  logic       tmo_hit;
  logic       set_berr, set_ill;
  logic       bad_inst;

  assign state   = state_q;
  // Timeout fires only while waiting; callers check mem_ready first so a late ready still wins.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TMO);

  // State, wait counter and sticky error flags; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (state_nx != state_q)
        wait_cnt <= 8'd0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      if (set_berr)
        bus_err <= 1'b1;
      if (set_ill)
        illegal <= 1'b1;
    end
  end

  // Next-state and strobe decode; everything defaults low and is forced low while in reset.
  always_comb begin
    state_nx = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    ir_we    = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    alu_ctl  = 4'd0;
    alu_bsel = 1'b0;
    set_berr = 1'b0;
    set_ill  = 1'b0;
    bad_inst = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        mem_sel = 1'b0;
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_nx = S_HALT;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_bsel = 1'b0;
            case (funct3)
              3'b111:  alu_ctl = 4'd0;
              3'b110:  alu_ctl = 4'd1;
              3'b100:  alu_ctl = 4'd3;
              3'b001:  alu_ctl = 4'd4;
              default: alu_ctl = 4'd2;
            endcase
            state_nx = S_WB;
          end
          OP_I: begin
            alu_bsel = 1'b1;
            alu_ctl  = (funct3 == 3'b101) ? 4'd7 : 4'd2;
            state_nx = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_ctl  = 4'd2;
            alu_bsel = 1'b1;
            state_nx = S_MEM;
          end
          OP_JALR: begin
            alu_ctl  = 4'd2;
            alu_bsel = 1'b1;
            rf_we    = 1'b1;
            wb_sel   = 2'd2;
            pc_we    = 1'b1;
            pc_src   = 2'd2;
            state_nx = S_FETCH;
          end
          OP_BR: begin
            if (funct3 == 3'b000 || funct3 == 3'b110) begin
              alu_ctl  = 4'd6;
              pc_we    = 1'b1;
              pc_src   = {1'b0, br_taken};
              state_nx = S_FETCH;
            end else begin
              bad_inst = 1'b1;
            end
          end
          default: bad_inst = 1'b1;
        endcase
        if (bad_inst) begin
`ifdef MC_CONTROL_TRAP_EN
          set_ill  = 1'b1;
          state_nx = S_HALT;
`else
          pc_we    = 1'b1;
          pc_src   = 2'd0;
          state_nx = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            pc_we    = 1'b1;
            pc_src   = 2'd0;
            state_nx = S_FETCH;
          end else begin
            mdr_we   = 1'b1;
            state_nx = S_WB;
          end
        end else if (tmo_hit) begin
          set_berr = 1'b1;
          state_nx = S_HALT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = (opcode == OP_LW) ? 2'd1 : 2'd0;
        pc_we    = 1'b1;
        pc_src   = 2'd0;
        state_nx = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_sel  = 1'b0;
      ir_we    = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      pc_we    = 1'b0;
      pc_src   = 2'd0;
      alu_ctl  = 4'd0;
      alu_bsel = 1'b0;
      set_berr = 1'b0;
      set_ill  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle expected outputs are queued as stimulus is driven
// and compared on the falling edge; MEM_TIMEOUT is set to 4 for the timeout cases.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, ir_we, mdr_we, rf_we, pc_we, alu_bsel;
  logic       bus_err, illegal;
  logic [1:0] wb_sel, pc_src;
  logic [3:0] alu_ctl;
  logic [2:0] state;

  mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_src(pc_src), .alu_ctl(alu_ctl), .alu_bsel(alu_bsel), .state(state),
    .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, mwe, msel, irwe, mdrwe, rfwe;
    logic [1:0] wbs;
    logic       pcwe;
    logic [1:0] pcs;
    logic [3:0] alu;
    logic       bsel, berr, ill;
  } obs_t;

  obs_t   obs;
  obs_t   sb[$];
  string  tq[$];
  int     nvec = 0;
  int     nerr = 0;
  logic   xb = 1'b0;
  logic   xi = 1'b0;

  assign obs = {state, mem_req, mem_we, mem_sel, ir_we, mdr_we, rf_we, wb_sel,
                pc_we, pc_src, alu_ctl, alu_bsel, bus_err, illegal};

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: observed %h expected %h (st/mreq/mwe/msel/irwe/mdrwe/rfwe/wbs/pcwe/pcs/alu/bsel/berr/ill)",
               tag, got, exp);
    end
  endtask

  // Pop one expectation per falling edge while the scoreboard holds entries.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      obs_t  e;
      string t;
      e = sb.pop_front();
      t = tq.pop_front();
      chk(t, obs, e);
    end
  end

  function automatic obs_t z(input logic [2:0] st);
    obs_t e;
    e      = '0;
    e.st   = st;
    e.berr = xb;
    e.ill  = xi;
    return e;
  endfunction

  task automatic step(input string tag, input logic mr, input logic br, input obs_t e);
    mem_ready = mr;
    br_taken  = br;
    sb.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    xb  = 1'b0;
    xi  = 1'b0;
    #3;
    chk({tag, "_async"}, obs, z(3'd0));
    @(posedge clk);
    #1;
    chk({tag, "_held"}, obs, z(3'd0));
    rst = 1'b0;
  endtask

  task automatic fd(input string tag, input logic [6:0] op, input logic [2:0] f3);
    obs_t e;
    opcode = op;
    funct3 = f3;
    e = z(3'd0); e.mreq = 1'b1; e.irwe = 1'b1;
    step({tag, "_fetch"}, 1'b1, 1'b0, e);
    e = z(3'd1);
    step({tag, "_decode"}, 1'b1, 1'b0, e);
  endtask

  task automatic wb(input string tag, input logic lw);
    obs_t e;
    e = z(3'd4); e.rfwe = 1'b1; e.wbs = lw ? 2'd1 : 2'd0; e.pcwe = 1'b1;
    step({tag, "_wb"}, 1'b1, 1'b0, e);
  endtask

  task automatic alu_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [3:0] alu, input logic bsel);
    obs_t e;
    fd(tag, op, f3);
    e = z(3'd2); e.alu = alu; e.bsel = bsel;
    step({tag, "_exec"}, 1'b1, 1'b0, e);
    wb(tag, 1'b0);
  endtask

  task automatic branch(input string tag, input logic [2:0] f3, input logic taken);
    obs_t e;
    fd(tag, 7'b1100011, f3);
    e = z(3'd2); e.alu = 4'd6; e.pcwe = 1'b1; e.pcs = taken ? 2'd1 : 2'd0;
    step({tag, "_exec"}, 1'b1, taken, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    do_reset("por");

    // ALU instructions: four cycles, WB writes rf and pc only.
    alu_op("addi", 7'b0010011, 3'b000, 4'd2, 1'b1);
    alu_op("srli", 7'b0010011, 3'b101, 4'd7, 1'b1);
    alu_op("ori",  7'b0010011, 3'b110, 4'd2, 1'b1);
    alu_op("and",  7'b0110011, 3'b111, 4'd0, 1'b0);
    alu_op("or",   7'b0110011, 3'b110, 4'd1, 1'b0);
    alu_op("xor",  7'b0110011, 3'b100, 4'd3, 1'b0);
    alu_op("sll",  7'b0110011, 3'b001, 4'd4, 1'b0);
    alu_op("add",  7'b0110011, 3'b000, 4'd2, 1'b0);

    // lw with three wait cycles in MEM.
    fd("lw", 7'b0000011, 3'b010);
    e = z(3'd2); e.alu = 4'd2; e.bsel = 1'b1;
    step("lw_exec", 1'b1, 1'b0, e);
    for (int i = 0; i < 3; i++) begin
      e = z(3'd3); e.mreq = 1'b1; e.msel = 1'b1;
      step("lw_wait", 1'b0, 1'b0, e);
    end
    e = z(3'd3); e.mreq = 1'b1; e.msel = 1'b1; e.mdrwe = 1'b1;
    step("lw_ready", 1'b1, 1'b0, e);
    wb("lw", 1'b1);

    // sw, ready immediately.
    fd("sw", 7'b0100011, 3'b010);
    e = z(3'd2); e.alu = 4'd2; e.bsel = 1'b1;
    step("sw_exec", 1'b1, 1'b0, e);
    e = z(3'd3); e.mreq = 1'b1; e.msel = 1'b1; e.mwe = 1'b1; e.pcwe = 1'b1;
    step("sw_mem", 1'b1, 1'b0, e);

    // Branches and jalr: three cycles, no register write for branches.
    branch("beq_t",  3'b000, 1'b1);
    branch("beq_nt", 3'b000, 1'b0);
    branch("bltu_t", 3'b110, 1'b1);
    fd("jalr", 7'b1100111, 3'b000);
    e = z(3'd2); e.alu = 4'd2; e.bsel = 1'b1; e.rfwe = 1'b1; e.wbs = 2'd2;
    e.pcwe = 1'b1; e.pcs = 2'd2;
    step("jalr_exec", 1'b1, 1'b0, e);

    // Unsupported opcode.
    fd("ill", 7'b1111111, 3'b000);
`ifdef MC_CONTROL_TRAP_EN
    e = z(3'd2);
    step("ill_exec", 1'b1, 1'b0, e);
    xi = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = z(3'd7);
      step("ill_halt", 1'b1, 1'b0, e);
    end
    do_reset("ill_rst");
`else
    e = z(3'd2); e.pcwe = 1'b1;
    step("ill_nop", 1'b1, 1'b0, e);
    alu_op("after_nop", 7'b0010011, 3'b000, 4'd2, 1'b1);
`endif

    // Fetch timeout: five cycles waiting, then HALT with bus_err.
    opcode = 7'b0010011;
    funct3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      e = z(3'd0); e.mreq = 1'b1;
      step("tmo_wait", 1'b0, 1'b0, e);
    end
    xb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = z(3'd7);
      step("tmo_halt", 1'b1, 1'b0, e);
    end
    do_reset("tmo_rst");

    // Ready on the fifth cycle wins over the timeout.
    for (int i = 0; i < 4; i++) begin
      e = z(3'd0); e.mreq = 1'b1;
      step("late_wait", 1'b0, 1'b0, e);
    end
    e = z(3'd0); e.mreq = 1'b1; e.irwe = 1'b1;
    step("late_ready", 1'b1, 1'b0, e);
    e = z(3'd1);
    step("late_decode", 1'b1, 1'b0, e);
    e = z(3'd2); e.alu = 4'd2; e.bsel = 1'b1;
    step("late_exec", 1'b1, 1'b0, e);
    wb("late", 1'b0);

    // Reset asserted mid-sw while MEM waits: strobes drop without a clock edge.
    fd("swr", 7'b0100011, 3'b010);
    e = z(3'd2); e.alu = 4'd2; e.bsel = 1'b1;
    step("swr_exec", 1'b1, 1'b0, e);
    mem_ready = 1'b0;
    e = z(3'd3); e.mreq = 1'b1; e.msel = 1'b1; e.mwe = 1'b1;
    sb.push_back(e);
    tq.push_back("swr_mem");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("swr_rst_async", obs, z(3'd0));
    @(posedge clk);
    #1;
    chk("swr_rst_held", obs, z(3'd0));
    rst = 1'b0;
    e = z(3'd0); e.mreq = 1'b1; e.irwe = 1'b1;
    step("swr_refetch", 1'b1, 1'b0, e);

    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles waiting for mem_ready in one FETCH/MEM visit; 0 disables the timeout; legal range 0..255.
REQ-002 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port opcode  input  7  instruction bits [6:0] from the external IR.
REQ-005 SHALL have port funct3  input  3  instruction bits [14:12] from the external IR.
REQ-006 SHALL have port br_taken  input  1  datapath compare result: rs1==rs2 for beq, rs1<rs2 unsigned for bltu.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-008 SHALL have outputs mem_req 1, mem_we 1 and mem_sel 1 (0 = instruction, 1 = data), the shared memory request.
REQ-009 SHALL have outputs ir_we 1 and mdr_we 1, the IR and memory-data-register load strobes.
REQ-010 SHALL have outputs rf_we 1 and wb_sel 2 (0 = ALU, 1 = MDR, 2 = PC+4), the register-file write strobe and source.
REQ-011 SHALL have outputs pc_we 1 and pc_src 2 (0 = PC+4, 1 = PC+branch imm, 2 = ALU), the PC update strobe and source.
REQ-012 SHALL have outputs alu_ctl 4 and alu_bsel 1 (0 = rs2, 1 = sign-extended imm), the ALU control.
REQ-013 SHALL have outputs state 3, bus_err 1 and illegal 1, the status outputs.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; `state` SHALL show the registered state.
REQ-015 All strobes SHALL be combinational decode of the registered state plus inputs; every strobe not named for a state SHALL be 0.
REQ-016 FETCH SHALL drive mem_req=1, mem_sel=0; when mem_ready=1 it SHALL drive ir_we=1 the same cycle and go to DECODE, otherwise stay in FETCH.
REQ-017 DECODE SHALL last exactly one cycle (register-file read) and then go to EXEC.
REQ-018 EXEC for opcode 0110011 SHALL set alu_bsel=0 and alu_ctl from funct3: 111->0, 110->1, 100->3, 001->4, other->2; it SHALL then go to WB.
REQ-019 EXEC for opcode 0010011 SHALL set alu_bsel=1 and alu_ctl from funct3: 101->7, 000->2, other->2; it SHALL then go to WB.
REQ-020 EXEC for opcode 0000011 (lw) or 0100011 (sw) SHALL set alu_ctl=2, alu_bsel=1 and go to MEM.
REQ-021 EXEC for opcode 1100111 (jalr) SHALL drive alu_ctl=2, alu_bsel=1, rf_we=1, wb_sel=2, pc_we=1, pc_src=2 and go to FETCH.
REQ-022 EXEC for opcode 1100011 with funct3 000 or 110 SHALL drive alu_ctl=6, pc_we=1 and pc_src=(br_taken?1:0), then go to FETCH.
REQ-023 MEM SHALL drive mem_req=1, mem_sel=1 and mem_we=1 only for sw; it SHALL hold until mem_ready=1.
REQ-024 On mem_ready in MEM, sw SHALL drive pc_we=1, pc_src=0 and go to FETCH; lw SHALL drive mdr_we=1 and go to WB.
REQ-025 WB SHALL drive rf_we=1, wb_sel (1 for lw, else 0), pc_we=1, pc_src=0, then go to FETCH.
REQ-026 Cycle counts with mem_ready held 1 SHALL be: R/I-type 4, lw 5, sw 4, branch 3, jalr 3.
REQ-027 An 8-bit wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_ready=0 there.
REQ-028 When the wait counter equals MEM_TIMEOUT (MEM_TIMEOUT!=0) with mem_ready=0, the next state SHALL be HALT and bus_err SHALL be set; mem_ready in the same cycle SHALL win over the timeout.
REQ-029 HALT SHALL deassert all strobes and SHALL be left only by reset; bus_err and illegal SHALL be sticky.

Reset
REQ-030 rst=1 SHALL immediately force state=FETCH, wait counter=0, bus_err=0, illegal=0, independent of clk.
REQ-031 While rst=1 all strobes, including mem_req, SHALL be 0; fetch SHALL start on the first clk edge after rst falls.
REQ-032 Reset mid-access SHALL abandon the access with no pc_we or rf_we issued.

Configuration
REQ-033 With macro MC_CONTROL_TRAP_EN defined, an unsupported opcode or branch funct3 in EXEC SHALL go to HALT with illegal=1.
REQ-034 Without MC_CONTROL_TRAP_EN, such instructions SHALL execute as NOP: pc_we=1, pc_src=0, go to FETCH; illegal SHALL stay 0.

Verification
REQ-035 Test: addi (0010011, f3 000), mem_ready=1 -> states 0,1,2,4,0; alu_ctl=2, alu_bsel=1; rf_we=1 and pc_we=1 only in WB.
REQ-036 Test: lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mdr_we=1 on the ready cycle, then WB with wb_sel=1.
REQ-037 Test: beq with br_taken=1, then beq with br_taken=0 -> 3 cycles each; pc_src=1 then 0; rf_we never asserted.
REQ-038 Test: MEM_TIMEOUT=4, mem_ready=0 in FETCH -> HALT after 5 cycles with bus_err=1; mem_ready on the 5th cycle -> DECODE, no error.
REQ-039 Test: opcode 1111111 -> HALT with illegal=1 when MC_CONTROL_TRAP_EN is defined; PC+4 and back to FETCH when it is not.
REQ-040 Test: rst pulsed mid-sw in MEM -> mem_req/mem_we drop without a clock edge; state=0; no pc_we issued.
